// File: rtl/addr_hash_pkg.sv
// ============================================================================
// Module : addr_hash_pkg
// Brief  : Shared types, refresh FSM states and the xorshift64 coefficient step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package addr_hash_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 64;

   typedef logic [ADDR_WIDTH_DEFAULT-1:0] addr_bits;

   // Coefficients live at full LFSR width; narrower address configs use the low bits.
   typedef logic [63:0] coef_t;

   localparam coef_t DEFAULT_SEED = 64'h9E3779B97F4A7C15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_GEN   = 2'd2
   } refresh_state_t;

   function automatic coef_t xorshift64(input coef_t x);
      coef_t y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

endpackage

`default_nettype wire

// File: rtl/coef_lfsr.sv
// ============================================================================
// Module : coef_lfsr
// Brief  : xorshift64 state register feeding coefficient regeneration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coef_lfsr
   import addr_hash_pkg::*;
#(
   parameter coef_t SEED = DEFAULT_SEED
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_step,
   output coef_t o_state
);

   // xorshift has an all-zero fixed point, so a zero seed falls back to the default.
   localparam coef_t c_seed = (SEED == '0) ? DEFAULT_SEED : SEED;

   coef_t r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_seed;
      end else if (i_step) begin
         r_state <= xorshift64(r_state);
      end
   end

   assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/addr_hash_pipe.sv
// ============================================================================
// Module : addr_hash_pipe
// Brief  : Two-stage multi-way universal address hash with LFSR coefficient refresh.
//          Define ADDR_HASH_COEF_LOAD_EN to add the direct coefficient write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addr_hash_pipe
   import addr_hash_pkg::*;
#(
   parameter int    ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
   parameter int    LG_NUM_BUCKETS = 2,
   parameter int    NUM_HASHES     = 4,
   parameter coef_t SEED           = DEFAULT_SEED
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [ADDR_WIDTH-1:0]                in_addr,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [NUM_HASHES*LG_NUM_BUCKETS-1:0] out_bucket,
   input  logic                                 refresh_req,
   output logic                                 refresh_busy
`ifdef ADDR_HASH_COEF_LOAD_EN
   ,
   input  logic                                 coef_we,
   input  logic [$clog2(2*NUM_HASHES)-1:0]      coef_idx,
   input  logic [ADDR_WIDTH-1:0]                coef_wdata
`endif
);

   localparam int c_NCOEF = 2 * NUM_HASHES;
   localparam int c_IDX_W = $clog2(c_NCOEF);
   localparam int c_HALF  = ADDR_WIDTH / 2;
   localparam int c_OUT_W = NUM_HASHES * LG_NUM_BUCKETS;

   refresh_state_t         r_state;
   logic                   r_busy;
   logic [c_IDX_W-1:0]     r_gen_idx;
   logic [ADDR_WIDTH-1:0]  r_coef [c_NCOEF];

   coef_t                  w_lfsr;
   logic                   w_lfsr_step;

   logic                   r_s1_valid;
   logic [ADDR_WIDTH-1:0]  r_prod [c_NCOEF];
   logic                   r_s2_valid;
   logic [c_OUT_W-1:0]     r_bucket;

   logic                   w_s1_adv;
   logic                   w_s2_adv;
   logic                   w_in_fire;
   logic [ADDR_WIDTH-1:0]  w_upper;
   logic [ADDR_WIDTH-1:0]  w_lower;
   logic [ADDR_WIDTH-1:0]  w_prod [c_NCOEF];
   logic [ADDR_WIDTH-1:0]  w_sum  [NUM_HASHES];
   logic [c_OUT_W-1:0]     w_bucket;

   assign w_s2_adv  = !r_s2_valid || out_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign in_ready  = !r_busy && w_s1_adv;
   assign w_in_fire = in_valid && in_ready;

   assign w_upper = {{c_HALF{1'b0}}, in_addr[ADDR_WIDTH-1:c_HALF]};
   assign w_lower = {{c_HALF{1'b0}}, in_addr[c_HALF-1:0]};

   // Products are taken at ADDR_WIDTH so the multiply itself truncates mod 2^AW.
   generate
      for (genvar g = 0; g < NUM_HASHES; g++) begin : g_way
         assign w_prod[2*g]   = w_upper * r_coef[2*g];
         assign w_prod[2*g+1] = w_lower * r_coef[2*g+1];
         assign w_sum[g]      = r_prod[2*g] + r_prod[2*g+1];
         assign w_bucket[g*LG_NUM_BUCKETS +: LG_NUM_BUCKETS] =
            w_sum[g][ADDR_WIDTH-1 -: LG_NUM_BUCKETS];
      end
   endgenerate

   coef_lfsr #(
      .SEED    (SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_step  (w_lfsr_step),
      .o_state (w_lfsr)
   );

   assign w_lfsr_step = (r_state == ST_GEN);

   // Reset lands directly in GEN so the automatic refresh needs no request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_GEN;
         r_busy    <= 1'b1;
         r_gen_idx <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (refresh_req) begin
                  r_state <= ST_DRAIN;
                  r_busy  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!r_s1_valid && !r_s2_valid) begin
                  r_state   <= ST_GEN;
                  r_gen_idx <= '0;
               end
            end
            ST_GEN: begin
               if (r_gen_idx == c_IDX_W'(c_NCOEF - 1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gen_idx <= r_gen_idx + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < c_NCOEF; k++) begin
            r_coef[k] <= '0;
         end
      end else begin
         for (int k = 0; k < c_NCOEF; k++) begin
            if (r_state == ST_GEN && r_gen_idx == c_IDX_W'(k)) begin
               r_coef[k] <= w_lfsr[ADDR_WIDTH-1:0] | {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
`ifdef ADDR_HASH_COEF_LOAD_EN
            else if (r_state == ST_IDLE && coef_we && coef_idx == c_IDX_W'(k)) begin
               r_coef[k] <= coef_wdata;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_bucket   <= '0;
         for (int k = 0; k < c_NCOEF; k++) begin
            r_prod[k] <= '0;
         end
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= w_in_fire;
         end
         if (w_in_fire) begin
            for (int k = 0; k < c_NCOEF; k++) begin
               r_prod[k] <= w_prod[k];
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s2_adv && r_s1_valid) begin
            r_bucket <= w_bucket;
         end
      end
   end

   assign out_valid    = r_s2_valid;
   assign out_bucket   = r_bucket;
   assign refresh_busy = r_busy;

endmodule

`default_nettype wire
